// File: rtl/vector_bram.sv
// Lane-masked simple-dual-port vector memory with self-clear after reset and write-first forwarding.
// Latency: read data/rd_valid appear 1 edge after the sampling edge (2 with VECTOR_BRAM_OUTREG_EN defined).
// Backpressure: none; ready low during the post-reset clear, requests then are dropped; full rate in RUN.
module vector_bram #(
    parameter  int LANE_WIDTH = 32,
    parameter  int LANES      = 4,
    parameter  int DEPTH      = 256,
    localparam int W          = LANES * LANE_WIDTH,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ready,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [LANES-1:0] wr_mask,
    input  logic [W-1:0]     wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [W-1:0]     rd_data,
    output logic             rd_valid
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

    logic [W-1:0] mem [DEPTH];

    state_t           state_q, state_d;
    logic [AW-1:0]    clear_cnt_q, clear_cnt_d;
    logic             ready_q, ready_d;
    // Stage A: request captured alongside the synchronous memory read
    logic             rd_vld_a_q, rd_vld_a_d;
    logic [LANES-1:0] fwd_mask_q, fwd_mask_d;
    logic [W-1:0]     fwd_data_q, fwd_data_d;
    logic [W-1:0]     ram_dout_q;
    // Memory output register
    logic             rd_valid_q, rd_valid_d;
    logic [W-1:0]     rd_data_q, rd_data_d;

    // Memory write port, shared between the init clear and user writes
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [LANES-1:0] mem_wmask;
    logic [W-1:0]     mem_wdata;
    logic [W-1:0]     rd_merge;

    // Next-state logic: init clear sequencing, request acceptance, collision capture
    always_comb begin
        state_d     = state_q;
        clear_cnt_d = clear_cnt_q;
        ready_d     = ready_q;
        rd_vld_a_d  = 1'b0;
        fwd_mask_d  = '0;
        fwd_data_d  = wr_data;
        mem_we      = 1'b0;
        mem_waddr   = wr_addr;
        mem_wmask   = wr_mask;
        mem_wdata   = wr_data;
        case (state_q)
            ST_INIT: begin
                // Requests are ignored; sweep zeros through every entry
                mem_we      = !rst;
                mem_waddr   = clear_cnt_q;
                mem_wmask   = '1;
                mem_wdata   = '0;
                clear_cnt_d = clear_cnt_q + AW'(1);
                if (clear_cnt_q == LAST_ADDR) begin
                    state_d     = ST_RUN;
                    ready_d     = 1'b1;
                    clear_cnt_d = '0;
                end
            end
            ST_RUN: begin
                // Out-of-range addresses (non power-of-2 depth) never touch the array
                mem_we     = wr_en && !rst && ({1'b0, wr_addr} < DEPTH_W);
                rd_vld_a_d = rd_en;
                if (wr_en && rd_en && (wr_addr == rd_addr)) begin
                    fwd_mask_d = wr_mask;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Write-first merge: colliding masked lanes take the captured write data
    always_comb begin
        rd_merge = '0;
        for (int i = 0; i < LANES; i++) begin
            rd_merge[i*LANE_WIDTH +: LANE_WIDTH] = fwd_mask_q[i] ?
                fwd_data_q[i*LANE_WIDTH +: LANE_WIDTH] :
                ram_dout_q[i*LANE_WIDTH +: LANE_WIDTH];
        end
    end

    // Output register loads only on a completing read, otherwise holds
    always_comb begin
        rd_valid_d = rd_vld_a_q;
        rd_data_d  = rd_vld_a_q ? rd_merge : rd_data_q;
    end

    // Array storage and synchronous read; no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (mem_we && mem_wmask[i]) begin
                mem[mem_waddr][i*LANE_WIDTH +: LANE_WIDTH] <= mem_wdata[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
        if (rd_en) begin
            ram_dout_q <= mem[rd_addr];
        end
    end

    // Control state and read pipeline, synchronous reset flushes everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            clear_cnt_q <= '0;
            ready_q     <= 1'b0;
            rd_vld_a_q  <= 1'b0;
            fwd_mask_q  <= '0;
            fwd_data_q  <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            clear_cnt_q <= clear_cnt_d;
            ready_q     <= ready_d;
            rd_vld_a_q  <= rd_vld_a_d;
            fwd_mask_q  <= fwd_mask_d;
            fwd_data_q  <= fwd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign ready = ready_q;

`ifdef VECTOR_BRAM_OUTREG_EN
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;

    // Extra output stage for timing, holds data between completing reads
    always_comb begin
        out_valid_d = rd_valid_q;
        out_data_d  = rd_valid_q ? rd_data_q : out_data_q;
    end

    // Extra output stage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign rd_valid = out_valid_q;
    assign rd_data  = out_data_q;
`else
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
`endif

endmodule

// File: tb/tb_vector_bram.sv
// Directed bench for vector_bram: init clear, masking, forwarding, throughput, reset flush.
// Inputs driven and outputs sampled on the falling edge.
// Expected values are hand-computed constants.
module tb_vector_bram;
    localparam int LW    = 32;
    localparam int LANES = 4;
    localparam int DEPTH = 256;
    localparam int W     = LANES * LW;
    localparam int AW    = 8;
`ifdef VECTOR_BRAM_OUTREG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    localparam logic [W-1:0] V_FULL  = 128'h44444444_33333333_22222222_11111111;
    localparam logic [W-1:0] V_PART  = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [W-1:0] V5_MASK = 128'h44444444_CCCCCCCC_22222222_AAAAAAAA;
    localparam logic [W-1:0] V9_COLL = 128'h00000000_00000000_FFFFFFFF_00000000;
    localparam logic [W-1:0] V5_COLL = 128'h99999999_CCCCCCCC_22222222_AAAAAAAA;

    logic             clk = 1'b0;
    logic             rst;
    logic             ready;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [LANES-1:0] wr_mask;
    logic [W-1:0]     wr_data;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [W-1:0]     rd_data;
    logic             rd_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vector_bram #(.LANE_WIDTH(LW), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_mask  (wr_mask),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [LANES-1:0] m, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_mask = m; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    // Issues one read (plus any write already set up), checks no early valid, then the result
    task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [W-1:0] exp);
        rd_en = 1'b1; rd_addr = a;
        step();
        rd_en = 1'b0; wr_en = 1'b0;
        chk({tag, " early_valid"}, W'(rd_valid), W'(1'b0));
        repeat (L) step();
        chk({tag, " valid"}, W'(rd_valid), W'(1'b1));
        chk({tag, " data"}, rd_data, exp);
    endtask

    // Counts cycles from reset release until ready; optionally pokes requests mid-INIT
    task automatic init_wait(input string tag, input bit poke);
        int cnt = 0;
        bit saw = 1'b0;
        while (!ready && cnt < 400) begin
            if (poke && cnt == 10) begin
                wr_en = 1'b1; wr_addr = 8'd3; wr_mask = '1; wr_data = {4{32'h5A5A5A5A}};
                rd_en = 1'b1; rd_addr = 8'd3;
            end
            step();
            cnt++;
            wr_en = 1'b0; rd_en = 1'b0;
            if (rd_valid) saw = 1'b1;
        end
        chk({tag, " ready_latency"}, W'(cnt), W'(DEPTH));
        chk({tag, " no_valid_in_init"}, W'(saw), W'(1'b0));
    endtask

    function automatic logic [W-1:0] low_exp(input int a);
        if (a == 5) return V5_COLL;
        if (a == 9) return V9_COLL;
        return '0;
    endfunction

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_mask = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0;

        // Reset state
        repeat (3) step();
        chk("rst ready", W'(ready), W'(1'b0));
        chk("rst rd_valid", W'(rd_valid), W'(1'b0));
        chk("rst rd_data", rd_data, '0);

        // INIT length and request rejection
        rst = 1'b0;
        init_wait("init0", 1'b1);

        // Every entry cleared (including addr 3 poked during INIT)
        for (int a = 0; a < DEPTH; a++) begin
            rd_chk($sformatf("zero[%0d]", a), AW'(a), '0);
        end

        // Lane-masked writes, read on the cycle right after the write
        wr(8'd5, 4'b1111, V_FULL);
        wr(8'd5, 4'b0101, V_PART);
        rd_chk("masked5", 8'd5, V5_MASK);
        step();
        chk("hold valid", W'(rd_valid), W'(1'b0));
        chk("hold data", rd_data, V5_MASK);

        // Same-cycle collision, write-first on masked lanes only
        wr_en = 1'b1; wr_addr = 8'd9; wr_mask = 4'b0010; wr_data = '1;
        rd_chk("coll9", 8'd9, V9_COLL);
        rd_chk("coll9 stored", 8'd9, V9_COLL);
        wr_en = 1'b1; wr_addr = 8'd5; wr_mask = 4'b1000; wr_data = {4{32'h99999999}};
        rd_chk("coll5", 8'd5, V5_COLL);

        // Back-to-back reads 0..15 with concurrent writes 100..115
        for (int c = 0; c <= 16 + L; c++) begin
            int idx;
            if (c < 16) begin
                rd_en = 1'b1; rd_addr = AW'(c);
                wr_en = 1'b1; wr_addr = AW'(100 + c); wr_mask = '1;
                wr_data = {4{32'(32'h10000000 + c)}};
            end else begin
                rd_en = 1'b0; wr_en = 1'b0;
            end
            step();
            idx = c - L;
            if (idx >= 0 && idx < 16) begin
                chk($sformatf("b2b valid[%0d]", idx), W'(rd_valid), W'(1'b1));
                chk($sformatf("b2b data[%0d]", idx), rd_data, low_exp(idx));
            end else begin
                chk($sformatf("b2b idle[%0d]", c), W'(rd_valid), W'(1'b0));
            end
        end
        rd_chk("b2b wr100", 8'd100, {4{32'h10000000}});
        rd_chk("b2b wr115", 8'd115, {4{32'h1000000F}});

        // Reset with a read in flight
        rd_en = 1'b1; rd_addr = 8'd107;
        step();
        rd_en = 1'b0; rst = 1'b1;
        step();
        chk("midrst rd_valid", W'(rd_valid), W'(1'b0));
        chk("midrst rd_data", rd_data, '0);
        chk("midrst ready", W'(ready), W'(1'b0));
        step();
        chk("midrst rd_valid2", W'(rd_valid), W'(1'b0));
        rst = 1'b0;
        init_wait("init1", 1'b0);
        rd_chk("post5", 8'd5, '0);
        rd_chk("post9", 8'd9, '0);
        rd_chk("post107", 8'd107, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vector_bram.md
# vector_bram

Lane-masked, simple-dual-port vector memory for the SIMD datapath: one write port and one read port on a single clock, storing LANES×LANE_WIDTH-bit vectors. It clears its own contents after reset, writes individual lanes selectively, forwards same-address writes to the read port, and flags returned data with a valid strobe. It replaces the flat single-port vector store as the register/scratch memory behind the SIMD lanes.

## Interface
- LANE_WIDTH, 32, bits per lane
- LANES, 4, lanes per vector; vector width W = LANES*LANE_WIDTH
- DEPTH, 256, vector entries; must be ≥2; AW = $clog2(DEPTH)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ready  out  1  high when the memory accepts reads and writes (init clear finished)
- wr_en  in  1  write request
- wr_addr  in  AW  write address
- wr_mask  in  LANES  per-lane write enable; bit i covers wr_data[i*LANE_WIDTH +: LANE_WIDTH]
- wr_data  in  W  write vector
- rd_en  in  1  read request
- rd_addr  in  AW  read address
- rd_data  out  W  read vector
- rd_valid  out  1  one-cycle strobe, rd_data holds the result of a read

## Operation
- States: INIT, RUN. rst forces INIT with the clear counter at 0. Reset values: ready=0, rd_valid=0, rd_data=0, pipeline valid bits=0.
- INIT: the block writes all-zero to entry clear_cnt each cycle, from 0 to DEPTH-1. After the cycle that writes DEPTH-1, it goes to RUN and sets ready=1. Clearing takes exactly DEPTH cycles.
- INIT ignores wr_en and rd_en. Reads are dropped (no rd_valid). Writes are lost. Callers must wait for ready.
- RUN: if wr_en, each lane i with wr_mask[i]=1 is written at wr_addr. Lanes with mask 0 keep their stored value. wr_mask=0 is a legal no-op.
- RUN: if rd_en, the vector at rd_addr is returned after the read latency, with rd_valid=1 in that cycle.
- Collision: rd_en and wr_en at the same address in the same cycle behave write-first per lane. Lanes with mask=1 return the new wr_data. Other lanes return the stored value.
- Different-address read and write in the same cycle are independent.
- rd_data holds its last value when no read completes. rd_valid is 0 in every cycle without a completing read.
- rst at any time (including mid-INIT or with reads in flight):
  - flushes in-flight reads (no rd_valid afterwards)
  - restarts INIT from entry 0
  - drops ready in the next cycle
  - clears rd_data to 0
- Address width is exactly AW. Addresses ≥DEPTH (non-power-of-2 DEPTH) are undefined to the caller. The block must not write outside the array.

## Timing
- Read latency L=1 by default: rd_en at edge N → rd_data/rd_valid registered at edge N+1. With VECTOR_BRAM_OUTREG_EN, L=2.
- Write takes effect at edge N. A read of the same address issued at edge N+1 or later returns the new data. Same-edge collision follows the forwarding rule above.
- Full throughput: one read and one write accepted every RUN cycle, no bubbles.
- ready rises at the first edge after the cycle that clears entry DEPTH-1. Requests in that same cycle are accepted.

## Configuration
- VECTOR_BRAM_OUTREG_EN defined: an extra output register stage is added after the memory read and forwarding mux. L=2, rd_valid is delayed to match, and both pipeline stages reset to 0/invalid.
- Not defined: L=1 and the memory output register drives rd_data directly.
- Functional behaviour (INIT, masking, forwarding, reset) is identical in both builds. Only latency differs.

## Test plan
- Reset then INIT (DEPTH=256):
  - hold rst 3 cycles, release → ready=0 for exactly 256 cycles, then 1
  - read of every address returns 0 with rd_valid after L cycles
- Masked write:
  - write addr 5 = 0x44444444_33333333_22222222_11111111, mask 4'b1111
  - then write addr 5 = 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, mask 4'b0101
  - read addr 5 → 0x44444444_CCCCCCCC_22222222_AAAAAAAA
- Collision forwarding:
  - addr 9 holds 0x0…0; same cycle: write addr 9 = all-F with mask 4'b0010, read addr 9
  - → rd_data = 0x00000000_00000000_FFFFFFFF_00000000, rd_valid at +L
- Back-to-back throughput:
  - reads of addrs 0..15 on 16 consecutive cycles, concurrent with writes to addrs 100..115
  - → 16 consecutive rd_valid pulses, correct data, no gaps
- Requests ignored during INIT:
  - wr_en addr 3 and rd_en during INIT → no rd_valid
  - after ready, addr 3 reads 0
- Mid-operation reset:
  - issue rd_en, assert rst the next cycle → rd_valid never asserts, rd_data=0, ready=0
  - INIT repeats 256 cycles, and previously written data reads back 0
